// File: rtl/vram_arbiter.sv
// Shares the text-module VRAM port between N_REQ clients: registered one-hot grant, owner-gated
// strobes, read-return routing and a hold watchdog. Define VRAM_ARB_RR_EN for round-robin arbitration.
module vram_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    output logic [N_REQ-1:0]        o_gnt,
    input  logic [N_REQ*ADDR_W-1:0] i_addr,
    input  logic [N_REQ*DATA_W-1:0] i_din,
    input  logic [N_REQ-1:0]        i_ce,
    input  logic [N_REQ-1:0]        i_w,
    output logic [DATA_W-1:0]       o_rdata,
    output logic [N_REQ-1:0]        o_rvalid,
    output logic [N_REQ-1:0]        o_timeout,
    output logic [ADDR_W-1:0]       o_vram_addr,
    output logic [DATA_W-1:0]       o_vram_din,
    output logic                    o_vram_ce,
    output logic                    o_vram_w,
    input  logic [DATA_W-1:0]       i_vram_dout
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t             state_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic [N_REQ-1:0]   blocked_reg;
    logic [N_REQ-1:0]   timeout_reg;
    logic [N_REQ-1:0]   rvalid_reg;
    logic [CNT_W-1:0]   hold_reg;

    logic [ADDR_W-1:0]  addr_term [N_REQ];
    logic [DATA_W-1:0]  din_term  [N_REQ];
    logic [ADDR_W-1:0]  addr_mux;
    logic [DATA_W-1:0]  din_mux;
    logic               own_req;
    logic               vram_ce;
    logic               vram_w;
    logic               rd_strobe;
    logic               release_own;
    logic               revoke;
    logic               wd_hit;
    logic [N_REQ-1:0]   cand;
    logic               win_any;
    logic [N_REQ-1:0]   win_onehot;

    // Owner select is an AND-OR over the one-hot grant, so no owner means all-zero outputs.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_term
            assign addr_term[gi] = gnt_reg[gi] ? i_addr[gi*ADDR_W +: ADDR_W] : '0;
            assign din_term[gi]  = gnt_reg[gi] ? i_din[gi*DATA_W +: DATA_W]  : '0;
        end
    endgenerate

    always_comb begin
        addr_mux = '0;
        din_mux  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            addr_mux = addr_mux | addr_term[k];
            din_mux  = din_mux  | din_term[k];
        end
    end

    assign own_req   = |(gnt_reg & i_req);
    assign vram_ce   = |(gnt_reg & i_req & i_ce);
    assign vram_w    = vram_ce & (|(gnt_reg & i_w));
    assign rd_strobe = vram_ce & ~vram_w;

    generate
        if (MAX_HOLD > 0) begin : g_wd
            assign wd_hit = (hold_reg == CNT_W'(MAX_HOLD - 1));
        end else begin : g_no_wd
            assign wd_hit = 1'b0;
        end
    endgenerate

    assign release_own = (state_reg == OWNED) & ~own_req;
    assign revoke      = (state_reg == OWNED) & own_req & wd_hit;

    // The current owner is masked out so a releasing or revoked owner cannot win the same edge.
    assign cand = i_req & ~blocked_reg & ~gnt_reg;

`ifdef VRAM_ARB_RR_EN
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] scan_idx;

    always_comb begin
        win_any    = 1'b0;
        win_onehot = '0;
        win_idx    = '0;
        scan_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            scan_idx = IDX_W'((int'(ptr_reg) + i) % N_REQ);
            if (!win_any && cand[scan_idx]) begin
                win_any             = 1'b1;
                win_onehot[scan_idx] = 1'b1;
                win_idx             = scan_idx;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_reg <= '0;
        end else if (win_any && (state_reg == IDLE || release_own || revoke)) begin
            ptr_reg <= win_idx;
        end
    end
`else
    always_comb begin
        win_any    = 1'b0;
        win_onehot = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_any       = 1'b1;
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            hold_reg    <= '0;
            blocked_reg <= '0;
            timeout_reg <= '0;
            rvalid_reg  <= '0;
        end else begin
            rvalid_reg  <= rd_strobe ? gnt_reg : '0;
            blocked_reg <= (blocked_reg & i_req) | (revoke ? gnt_reg : '0);
            if (revoke) begin
                timeout_reg <= timeout_reg | gnt_reg;
            end
            case (state_reg)
                IDLE: begin
                    hold_reg <= '0;
                    if (win_any) begin
                        state_reg <= OWNED;
                        gnt_reg   <= win_onehot;
                    end
                end
                OWNED: begin
                    if (release_own || revoke) begin
                        hold_reg <= '0;
                        if (win_any) begin
                            gnt_reg <= win_onehot;
                        end else begin
                            gnt_reg   <= '0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        hold_reg <= hold_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_gnt       = gnt_reg;
    assign o_rvalid    = rvalid_reg;
    assign o_timeout   = timeout_reg;
    assign o_rdata     = i_vram_dout;
    assign o_vram_addr = addr_mux;
    assign o_vram_din  = din_mux;
    assign o_vram_ce   = vram_ce;
    assign o_vram_w    = vram_w;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single VRAM port of the text/LCD block and shares it between the terminal's VRAM clients: scroll, clear, putchar and the host cursor port.
- Replaces ad-hoc "running ? x : y" muxing with a registered request/grant handshake, gated strobes, read-data routing and a hold watchdog.
- Sits between the client engines and the text module's i_vram_* port, on the 12 MHz system clock.

Parameters:
- N_REQ, 4, number of requesters; index 0 is highest fixed priority (0 scroll, 1 clear, 2 putchar, 3 host).
- ADDR_W, 11, VRAM address width ({5'row, 6'col}).
- DATA_W, 8, VRAM data width.
- MAX_HOLD, 4096, maximum consecutive granted cycles before forced revoke; 0 disables the watchdog.

Ports:
- i_clk  in  1  system clock (12 MHz).
- i_rst  in  1  asynchronous active-high reset.
- i_req  in  N_REQ  per-requester request; held high for the whole burst.
- o_gnt  out  N_REQ  one-hot (or zero) registered grant.
- i_addr  in  N_REQ*ADDR_W  flattened per-requester address; requester k uses bits [k*ADDR_W +: ADDR_W].
- i_din  in  N_REQ*DATA_W  flattened per-requester write data.
- i_ce  in  N_REQ  per-requester access strobe.
- i_w  in  N_REQ  per-requester write (1) / read (0).
- o_rdata  out  DATA_W  VRAM read data, broadcast to all requesters.
- o_rvalid  out  N_REQ  one-hot; marks o_rdata valid for requester k.
- o_timeout  out  N_REQ  sticky per-requester watchdog flag.
- o_vram_addr  out  ADDR_W  to the text module.
- o_vram_din  out  DATA_W  to the text module.
- o_vram_ce  out  1  to the text module.
- o_vram_w  out  1  to the text module.
- i_vram_dout  in  DATA_W  from the text module; valid 1 cycle after a read strobe.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_gnt=0, o_rvalid=0, o_timeout=0, hold counter=0, blocked mask=0, RR pointer=0.
- States:
  - IDLE: no owner.
  - OWNED: exactly one o_gnt bit high.
- IDLE:
  - At each edge, pick the winner among i_req & ~blocked.
  - Register o_gnt[winner]=1 and go to OWNED.
  - Grant latency is 1 cycle from request.
- OWNED:
  - If the owner's i_req=0 at an edge, release.
  - A new winner may be granted at that same edge, with no bubble, excluding the releasing owner for that one edge.
  - Requests from other requesters never preempt the owner.
- VRAM strobes are combinational from the owner's lines:
  - o_vram_ce = i_ce[own] & i_req[own] & gnt.
  - o_vram_w = i_w[own] & o_vram_ce.
  - o_vram_addr and o_vram_din are the owner's lines.
  - With no owner, all VRAM outputs are 0.
- Read routing:
  - A granted read (ce=1, w=0) at cycle t sets o_rvalid[own]=1 at t+1 for one cycle.
  - o_rdata = i_vram_dout, registered pass-through alignment.
  - The return is delivered even if the owner released at t+1.
  - Writes never raise o_rvalid.
- Watchdog (MAX_HOLD>0):
  - The counter increments every OWNED cycle and clears on release or grant change.
  - When it reaches MAX_HOLD-1 at an edge, the grant is revoked at that edge.
  - On revoke, o_timeout[own] is set (sticky until reset) and blocked[own] is set.
  - blocked[k] clears at the first edge where i_req[k]=0.
  - A blocked requester is never granted.
- Simultaneous release and new requests: re-arbitrate normally. Requests that drop before grant are simply not granted.
- Reset mid-burst: grant drops immediately (async). Any in-flight o_rvalid is cancelled.

Optional Feature:
- Macro: VRAM_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at (last owner + 1) mod N_REQ. The pointer updates on each grant. Reset pointer is 0.
- Undefined: fixed priority, lowest index wins. No pointer register exists.

Test Plan:
- Reset, then i_req=4'b0100 with ce=1, w=1, addr=11'h045, din=8'h41 -> o_gnt=4'b0100 next cycle; o_vram_ce=1, o_vram_w=1, addr 11'h045, din 8'h41 while granted; all VRAM outputs 0 after release.
- i_req=4'b1111 at the same edge (fixed priority) -> grants in order 0,1,2,3 as each releases, with no idle cycle between grants. With VRAM_ARB_RR_EN and owner 1 releasing while 0 and 3 still request -> next grant goes to 3.
- Requester 0 reads addr 11'h020 holding value 8'h5A -> o_rvalid=4'b0001 and o_rdata=8'h5A exactly 1 cycle after the strobe; the value is still delivered when req drops in that cycle.
- Requester 2 granted and requester 0 raises req mid-burst -> no preemption; 0 is granted on the edge where 2's req is sampled low.
- MAX_HOLD=8, requester 1 holds req for 20 cycles -> grant revoked after 8 granted cycles; o_timeout=4'b0010 stays sticky; 1 is not regranted until its req goes low and high again.
- i_rst asserted mid-burst, asynchronously between edges -> o_gnt, o_vram_ce and o_rvalid go to 0 immediately; o_timeout clears.
